demux_1x2_stream: RTL and testbench
===================================

# demux_1x2_stream

Routes one valid/ready data stream to one of two output streams, the inverse of the two-input select path. The route is chosen by `s` on the first beat of each packet and held until the packet's `last` beat. Each output has a one-entry register slice, so paths are registered, latency is 1 cycle and throughput is 1 beat/cycle. It sits between a single producer (e.g. a UART/SPI front end) and two consumers.

## Interface
Parameters:
- `N`, 4, data width in bits.
- `CNT_W`, 16, width of per-port beat counters (used only when `DEMUX_STATS_EN` is defined).

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `reset_n`  in  1  asynchronous active-low reset.
- `in_data`  in  N  input beat data.
- `in_valid`  in  1  input beat is present.
- `in_last`  in  1  input beat is the final beat of its packet.
- `in_ready`  out  1  input beat is accepted when `in_valid && in_ready`.
- `s`  in  1  route select, sampled only on the first beat of a packet; 0 selects out0, 1 selects out1.
- `out0_data`, `out1_data`  out  N  output beat data.
- `out0_valid`, `out1_valid`  out  1  output beat is present.
- `out0_last`, `out1_last`  out  1  output beat is the final beat of its packet.
- `out0_ready`, `out1_ready`  in  1  sink accepts the beat.
- `sel_q`  out  1  route currently locked in.
- `busy`  out  1  high while a packet is partially transferred (FSM in ROUTE).
- `cnt0`, `cnt1`  out  CNT_W  beats delivered per port; present only when `DEMUX_STATS_EN` is defined.

## Operation
- FSM states: IDLE and ROUTE.
- In IDLE, target = `s`. When a beat is accepted, `sel_q` <= `s`. If `in_last`=0 the FSM goes to ROUTE; if `in_last`=1 (single-beat packet) it stays in IDLE.
- In ROUTE, target = `sel_q` and `s` is ignored. When a beat with `in_last`=1 is accepted, the FSM goes to IDLE.
- `in_ready` = can_accept of the target slice. It is combinational from that slice's full flag and its `outX_ready`.
- Each slice is one entry with a full flag. can_accept = !full || outX_ready, so the slice drains and refills in the same cycle at full rate.
- The non-target slice keeps draining independently. Its data holds the last value when empty.
- Output rules:
  - `outX_valid` stays high until `outX_ready`.
  - `outX_data` and `outX_last` are stable while `outX_valid` is high and `outX_ready` is low.
- Source rule: the producer holds `in_data` and `in_last` stable while `in_valid` is high and `in_ready` is low. The block does not check this rule.
- Boundary behaviour:
  - A change on `s` mid-packet has no effect on routing.
  - Target slice full with its sink not ready: `in_ready`=0, no beat is lost.
  - Non-target slice full: no effect on `in_ready`.
  - Reset mid-packet: buffered beats are dropped, the FSM returns to IDLE and the next beat is treated as a packet start.

## Timing
- Reset values: `outX_valid`=0, `outX_data`=0, `outX_last`=0, `sel_q`=0, `busy`=0, FSM=IDLE, `cnt0`/`cnt1`=0.
- Latency: a beat accepted at edge k appears on `outX` after edge k, and can be accepted by the sink at edge k+1.
- Throughput is 1 beat/cycle per active route with no bubbles at packet boundaries, including a switch from out0 to out1 on back-to-back packets.
- `busy` and `sel_q` are registered and update on the accepting edge.

## Configuration
- `DEMUX_STATS_EN` defined: `cnt0` and `cnt1` count `outX_valid && outX_ready` handshakes. They wrap modulo 2^CNT_W and are cleared by reset.
- `DEMUX_STATS_EN` not defined: the counter ports and logic are absent and the rest of the behaviour is identical.

## Structure
- Package `demux_pkg` holds:
  - `typedef enum logic {IDLE, ROUTE} demux_state_t`.
  - `typedef enum logic {PORT0=1'b0, PORT1=1'b1} demux_port_t`.
- Sub-module `demux_out_slice` (parameter N): one-entry register slice with `clk`, `reset_n`, load, data/last in, valid/ready/data/last out, and can_accept. It is instantiated twice.

## Test plan
- Reset, then idle: all outputs 0, `in_ready`=1 with `out0_ready`=`out1_ready`=1.
- Single-beat packet with `s`=1, data 4'hA, `last`=1 -> `out1` shows 4'hA with `last`=1 one cycle later; `out0_valid` stays 0; `sel_q`=1, `busy`=0.
- 3-beat packet (1,2,3) started with `s`=0, and `s` toggled to 1 on beat 2 -> all three beats appear on `out0`; `busy`=1 from the first-beat acceptance edge until the beat-3 (`last`) acceptance edge.
- `out0_ready`=0 for 5 cycles during a 4-beat out0 packet -> `in_ready`=0 after the slice fills, no beat is lost or duplicated, and `out1` traffic is unaffected.
- Back-to-back packets out0 then out1, with both sinks always ready -> no idle cycle between packets and the correct beats arrive at each port.
- `reset_n` pulsed low mid-packet while a slice is full -> valids drop to 0 asynchronously; the next beat after reset is routed by the current `s`. With `DEMUX_STATS_EN`, the counters read 0 after reset and 0xFFFF wraps to 0 after one more delivered beat.

Source files
------------

// File: rtl/demux_pkg.sv
// demux_pkg: shared state and port types for demux_1x2_stream
package demux_pkg;
  typedef enum logic {IDLE, ROUTE} demux_state_t;
  typedef enum logic {PORT0 = 1'b0, PORT1 = 1'b1} demux_port_t;
endpackage

// File: rtl/demux_out_slice.sv
// demux_out_slice: one-entry register slice; drains and refills in the same cycle
module demux_out_slice #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [N-1:0] in_data,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         out_last,
  output logic         can_accept
);
  assign can_accept = !out_valid || out_ready;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
      out_last  <= in_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
endmodule

// File: rtl/demux_1x2_stream.sv
// demux_1x2_stream: packet-locked 1-to-2 stream demux; DEMUX_STATS_EN adds per-port beat counters cnt0/cnt1
module demux_1x2_stream
  import demux_pkg::*;
#(
  parameter int N     = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N-1:0]     in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  input  logic             s,
  output logic [N-1:0]     out0_data,
  output logic             out0_valid,
  output logic             out0_last,
  input  logic             out0_ready,
  output logic [N-1:0]     out1_data,
  output logic             out1_valid,
  output logic             out1_last,
  input  logic             out1_ready,
  output logic             sel_q,
  output logic             busy
`ifdef DEMUX_STATS_EN
  ,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
`endif
);
  demux_state_t state, state_nx;
  demux_port_t  target;
  logic         sel_nx, acc, load0, load1, ca0, ca1;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      sel_q <= 1'b0;
    end else begin
      state <= state_nx;
      sel_q <= sel_nx;
    end
  // In ROUTE the target already equals sel_q, so latching it on every accept is harmless
  always_comb begin
    state_nx = acc ? (in_last ? IDLE : ROUTE) : state;
    sel_nx   = acc ? target : sel_q;
  end
  always_comb begin
    target   = (state == IDLE) ? demux_port_t'(s) : demux_port_t'(sel_q);
    in_ready = (target == PORT1) ? ca1 : ca0;
    acc      = in_valid && in_ready;
    load0    = acc && target == PORT0;
    load1    = acc && target == PORT1;
    busy     = state == ROUTE;
  end
  demux_out_slice #(.N(N)) u_slice0 (
    .clk(clk), .reset_n(reset_n), .load(load0), .in_data(in_data), .in_last(in_last),
    .out_valid(out0_valid), .out_ready(out0_ready), .out_data(out0_data), .out_last(out0_last),
    .can_accept(ca0)
  );
  demux_out_slice #(.N(N)) u_slice1 (
    .clk(clk), .reset_n(reset_n), .load(load1), .in_data(in_data), .in_last(in_last),
    .out_valid(out1_valid), .out_ready(out1_ready), .out_data(out1_data), .out_last(out1_last),
    .can_accept(ca1)
  );
`ifdef DEMUX_STATS_EN
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      cnt0 <= cnt0 + CNT_W'(out0_valid && out0_ready);
      cnt1 <= cnt1 + CNT_W'(out1_valid && out1_ready);
    end
`else
  logic unused_cnt_w;
  assign unused_cnt_w = ^CNT_W;
`endif
endmodule

// File: tb/tb_demux_1x2_stream.sv
// tb_demux_1x2_stream: random and directed stimulus against a queue-based scoreboard
module tb_demux_1x2_stream;
  logic        clk, reset_n;
  logic [3:0]  in_data, out0_data, out1_data;
  logic        in_valid, in_last, in_ready, s;
  logic        out0_valid, out0_last, out0_ready, out1_valid, out1_last, out1_ready;
  logic        sel_q, busy;
`ifdef DEMUX_STATS_EN
  logic [15:0] cnt0, cnt1;
`endif
  int          n_cmp = 0, n_err = 0, stall0 = 0, t;
  logic        acc;
  logic [4:0]  q0[$], q1[$];
  logic        in_pkt, sel_m;
  logic [15:0] cnt0_m, cnt1_m;
  demux_1x2_stream #(.N(4), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .s(s),
    .out0_data(out0_data), .out0_valid(out0_valid), .out0_last(out0_last), .out0_ready(out0_ready),
    .out1_data(out1_data), .out1_valid(out1_valid), .out1_last(out1_last), .out1_ready(out1_ready),
`ifdef DEMUX_STATS_EN
    .cnt0(cnt0), .cnt1(cnt1),
`endif
    .sel_q(sel_q), .busy(busy)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic model_clear();
    q0.delete(); q1.delete();
    in_pkt = 1'b0; sel_m = 1'b0; cnt0_m = '0; cnt1_m = '0;
  endtask
  // One clock: drive at negedge, check state left by the previous edge, advance the model
  task automatic cyc(input logic v, input logic [3:0] d, input logic l, input logic sv,
                     input logic r0, input logic r1);
    logic tgt, er;
    @(negedge clk);
    in_valid = v; in_data = d; in_last = l; s = sv;
    out0_ready = r0 && stall0 == 0; out1_ready = r1;
    if (stall0 != 0) stall0--;
    #1;
    chk("out0_valid", out0_valid, q0.size() != 0);
    if (q0.size() != 0) begin chk("out0_data", out0_data, q0[0][3:0]); chk("out0_last", out0_last, q0[0][4]); end
    chk("out1_valid", out1_valid, q1.size() != 0);
    if (q1.size() != 0) begin chk("out1_data", out1_data, q1[0][3:0]); chk("out1_last", out1_last, q1[0][4]); end
    chk("sel_q", sel_q, sel_m);
    chk("busy", busy, in_pkt);
`ifdef DEMUX_STATS_EN
    chk("cnt0", cnt0, cnt0_m);
    chk("cnt1", cnt1, cnt1_m);
`endif
    tgt = in_pkt ? sel_m : sv;
    er = tgt ? (q1.size() == 0 || out1_ready) : (q0.size() == 0 || out0_ready);
    chk("in_ready", in_ready, er);
    acc = v && er;
    if (q0.size() != 0 && out0_ready) begin void'(q0.pop_front()); cnt0_m++; end
    if (q1.size() != 0 && out1_ready) begin void'(q1.pop_front()); cnt1_m++; end
    if (acc) begin
      if (tgt) q1.push_back({l, d}); else q0.push_back({l, d});
      if (!in_pkt) sel_m = sv;
      in_pkt = !l;
    end
  endtask
  task automatic send(input logic [3:0] d, input logic l, input logic sv,
                      input logic r0, input logic r1, output int tries);
    tries = 0; acc = 1'b0;
    while (!acc && tries < 50) begin cyc(1'b1, d, l, sv, r0, r1); tries++; end
    if (!acc) chk("send_timeout", 0, 1);
  endtask
  initial begin
    logic v, l, sv, r0, r1;
    logic [3:0] d;
    reset_n = 1'b0; in_valid = 0; in_data = 0; in_last = 0; s = 0; out0_ready = 1; out1_ready = 1;
    model_clear();
    repeat (3) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    chk("rst_out0_data", out0_data, 0);
    chk("rst_out1_data", out1_data, 0);
    chk("rst_out0_last", out0_last, 0);
    chk("rst_out1_last", out1_last, 0);
    cyc(0, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 1, 1);
    send(4'hA, 1, 1, 1, 1, t);
    cyc(0, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 1, 1);
    send(4'h1, 0, 0, 1, 1, t);
    send(4'h2, 0, 1, 1, 1, t);
    send(4'h3, 1, 1, 1, 1, t);
    repeat (2) cyc(0, 0, 0, 1, 1, 1);
    send(4'h4, 0, 0, 1, 1, t); chk("b2b_tries0", t, 1);
    send(4'h5, 1, 0, 1, 1, t); chk("b2b_tries1", t, 1);
    send(4'h6, 0, 1, 1, 1, t); chk("b2b_tries2", t, 1);
    send(4'h7, 1, 1, 1, 1, t); chk("b2b_tries3", t, 1);
    cyc(0, 0, 0, 0, 1, 1);
    send(4'h9, 1, 1, 1, 0, t);
    stall0 = 5;
    send(4'h1, 0, 0, 1, 0, t);
    send(4'h2, 0, 1, 1, 0, t); chk("stall_tries", t, 5);
    send(4'h3, 0, 1, 1, 0, t);
    send(4'h4, 1, 0, 1, 0, t);
    repeat (3) cyc(0, 0, 0, 0, 1, 1);
    send(4'hC, 0, 0, 0, 1, t);
    @(negedge clk);
    in_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("arst_out0_valid", out0_valid, 0);
    chk("arst_out1_valid", out1_valid, 0);
    chk("arst_busy", busy, 0);
    model_clear();
    @(negedge clk) reset_n = 1'b1;
    send(4'hE, 1, 1, 1, 1, t);
    cyc(0, 0, 0, 0, 1, 1);
    v = 0; l = 0; d = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!(v && !acc)) begin
        v = ($urandom % 4) != 0; d = 4'($urandom); l = ($urandom % 3) == 0;
      end
      sv = 1'($urandom); r0 = ($urandom % 4) != 0; r1 = ($urandom % 4) != 0;
      cyc(v, d, l, sv, r0, r1);
    end
    repeat (3) cyc(0, 0, 0, 0, 1, 1);
`ifdef DEMUX_STATS_EN
    for (int i = 0; i < 70000 && cnt0_m != 16'hFFFF; i++) cyc(1, 4'h3, 1, 0, 1, 1);
    repeat (3) cyc(0, 0, 0, 0, 1, 1);
    chk("cnt0_wrap", cnt0, 16'h0000);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
